// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with pause, synchronous abort and a
// one-cycle terminal-count flag. All outputs come straight from registers.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to make the timer reload
// from the captured start value after each terminal count (periodic mode).
// Without the macro the timer is single-shot and returns to IDLE after DONE.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             pause,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_reload;
  logic             r_busy;
  logic             r_done;

  // State machine, counter, reload capture and registered busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= CNT_ZERO;
      r_reload <= CNT_ZERO;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (clr) begin
      // Abort wins over everything: drop the count, never flag done.
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_reload <= load_val;
            if (load_val == CNT_ZERO) begin
              // Zero load terminates immediately without ever being busy.
              r_state <= ST_DONE;
              r_cnt   <= CNT_ZERO;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_cnt   <= load_val;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
            r_busy  <= 1'b0;
          end
        end

        // RUN and PAUSE share the same counting rule; the edge that sees
        // pause drop already decrements, so each pause-high cycle costs
        // exactly one cycle of delay.
        ST_RUN, ST_PAUSE: begin
          if (pause) begin
            r_state <= ST_PAUSE;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end else if (r_cnt > CNT_ONE) begin
            r_state <= ST_RUN;
            r_cnt   <= r_cnt - CNT_ONE;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end else begin
            // Count of one (or a zero that cannot occur) terminates here,
            // so the counter never wraps.
            r_state <= ST_DONE;
            r_cnt   <= CNT_ZERO;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        ST_DONE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if (r_reload == CNT_ZERO) begin
            // Nothing to count: stay terminal, flag every cycle.
            r_state <= ST_DONE;
            r_cnt   <= CNT_ZERO;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_RUN;
            r_cnt   <= r_reload;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
`else
          r_state <= ST_IDLE;
          r_cnt   <= CNT_ZERO;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
`endif
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= CNT_ZERO;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign cnt  = r_cnt;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer (WIDTH=4). Stimulus pushes the
// hand-computed post-edge output into a queue; a monitor pops and compares.
module tb_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       start;
  logic [3:0] load_val;
  logic       pause;
  logic [3:0] cnt;
  logic       busy;
  logic       done;

  typedef struct {
    string      name;
    logic [3:0] c;
    logic       b;
    logic       d;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  countdown_timer #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .start    (start),
    .load_val (load_val),
    .pause    (pause),
    .cnt      (cnt),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [3:0] ec,
                         input logic eb, input logic ed);
    n_vec++;
    if (cnt !== ec || busy !== eb || done !== ed) begin
      n_err++;
      $display("FAIL %s: got cnt=%0d busy=%0b done=%0b, expected cnt=%0d busy=%0b done=%0b",
               name, cnt, busy, done, ec, eb, ed);
    end
  endtask

  // Monitor: outputs are valid every cycle; check 1ns after each rising edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      compare(e.name, e.c, e.b, e.d);
    end
  end

  task automatic step(input string name, input logic st, input logic [3:0] lv,
                      input logic ps, input logic cl, input logic [3:0] ec,
                      input logic eb, input logic ed);
    exp_t e;
    @(negedge clk);
    start    = st;
    load_val = lv;
    pause    = ps;
    clr      = cl;
    e.name = name; e.c = ec; e.b = eb; e.d = ed;
    sb_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle(input string name, input logic [3:0] ec,
                      input logic eb, input logic ed);
    step(name, 1'b0, 4'd0, 1'b0, 1'b0, ec, eb, ed);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() > 0 && k < 20) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (sb_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    start = 1'b0; load_val = 4'd0; pause = 1'b0; clr = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 compare("reset_state", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Periodic mode: load 3 -> 3,2,1,0(done),3,2,1,0(done),3; clr stops it.
    step("auto_load", 1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0);
    idle("auto_2", 4'd2, 1'b1, 1'b0);
    idle("auto_1", 4'd1, 1'b1, 1'b0);
    idle("auto_done1", 4'd0, 1'b0, 1'b1);
    idle("auto_reload1", 4'd3, 1'b1, 1'b0);
    idle("auto_2b", 4'd2, 1'b1, 1'b0);
    idle("auto_1b", 4'd1, 1'b1, 1'b0);
    idle("auto_done2", 4'd0, 1'b0, 1'b1);
    idle("auto_reload2", 4'd3, 1'b1, 1'b0);
    step("auto_clr", 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    idle("auto_stopped1", 4'd0, 1'b0, 1'b0);
    idle("auto_stopped2", 4'd0, 1'b0, 1'b0);
    // Zero reload: done stays high every cycle until clr.
    step("auto_zero", 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    idle("auto_zero_hold1", 4'd0, 1'b0, 1'b1);
    idle("auto_zero_hold2", 4'd0, 1'b0, 1'b1);
    step("auto_zero_clr", 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    idle("auto_zero_idle", 4'd0, 1'b0, 1'b0);
`else
    // Basic count of 5.
    step("basic_load", 1'b1, 4'd5, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
    for (int i = 4; i >= 1; i--) idle("basic_dec", 4'(i), 1'b1, 1'b0);
    idle("basic_done", 4'd0, 1'b0, 1'b1);
    idle("basic_idle", 4'd0, 1'b0, 1'b0);
    idle("basic_idle2", 4'd0, 1'b0, 1'b0);

    // Pause three cycles while cnt=2; done at edge k+7.
    step("pause_load", 1'b1, 4'd4, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0);
    idle("pause_3", 4'd3, 1'b1, 1'b0);
    idle("pause_2", 4'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step("pause_hold", 1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
    idle("pause_resume", 4'd1, 1'b1, 1'b0);
    idle("pause_done", 4'd0, 1'b0, 1'b1);
    idle("pause_idle", 4'd0, 1'b0, 1'b0);

    // Zero load: done next cycle, never busy.
    step("zero_load", 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    idle("zero_idle", 4'd0, 1'b0, 1'b0);

    // Max load: 15 down to 0, no wrap.
    step("max_load", 1'b1, 4'd15, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0);
    for (int i = 14; i >= 1; i--) idle("max_dec", 4'(i), 1'b1, 1'b0);
    idle("max_done", 4'd0, 1'b0, 1'b1);
    idle("max_nowrap1", 4'd0, 1'b0, 1'b0);
    idle("max_nowrap2", 4'd0, 1'b0, 1'b0);

    // Start during RUN is ignored.
    step("ign_load", 1'b1, 4'd6, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0);
    step("ign_start", 1'b1, 4'd9, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
    for (int i = 4; i >= 1; i--) idle("ign_dec", 4'(i), 1'b1, 1'b0);
    idle("ign_done", 4'd0, 1'b0, 1'b1);
    idle("ign_idle", 4'd0, 1'b0, 1'b0);

    // Abort at cnt=3; clr also beats a simultaneous start.
    step("clr_load", 1'b1, 4'd5, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
    idle("clr_4", 4'd4, 1'b1, 1'b0);
    idle("clr_3", 4'd3, 1'b1, 1'b0);
    step("clr_abort", 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    idle("clr_nodone1", 4'd0, 1'b0, 1'b0);
    idle("clr_nodone2", 4'd0, 1'b0, 1'b0);
    step("clr_vs_start", 1'b1, 4'd5, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    idle("clr_vs_start_idle", 4'd0, 1'b0, 1'b0);

    // Abort while paused.
    step("clrp_load", 1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0);
    step("clrp_pause", 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
    step("clrp_abort", 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    idle("clrp_idle", 4'd0, 1'b0, 1'b0);
`endif

    // Asynchronous reset between edges mid-count.
    step("rst_load", 1'b1, 4'd7, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0);
    idle("rst_6", 4'd6, 1'b1, 1'b0);
    drain();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 compare("rst_async", 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 compare("rst_held", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_load", 1'b1, 4'd2, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
    idle("post_rst_1", 4'd1, 1'b1, 1'b0);
    idle("post_rst_done", 4'd0, 1'b0, 1'b1);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    idle("post_rst_idle", 4'd0, 1'b0, 1'b0);
`else
    idle("post_rst_reload", 4'd2, 1'b1, 1'b0);
`endif
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
